store_unit: RTL and testbench

Execution-unit block that performs RV32 stores (SB, SH, SW), the write-side counterpart of the load path to the data cache controller. It accepts one store per operation and latches the address, data and instruction packet. It aligns the data into the 32-bit word lane and generates byte enables. It then issues a single write request to the cache controller and holds it until the controller acknowledges completion. Misaligned and reserved operations are rejected without touching memory and are reported to the commit logic.

---
 rtl/store_unit_if.sv | 61 ++++++
 rtl/store_unit.sv | 175 +++++++++++++++++
 tb/tb_store_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_unit_if.sv
// rtl/store_unit_if.sv - shared store-unit types and the cache-controller write interface
//
// store_unit_pkg : stu_operation_t, instr_packet_t, cachable region bounds
// store_unit_if  : write-side bus between the store unit and the data cache controller
//   cache_ctrl_idle_i        controller -> unit  controller can accept a request
//   cache_ctrl_write_done_i  controller -> unit  write completed
//   cache_ctrl_write_o       unit -> controller  write request (level)
//   cache_ctrl_address_o     unit -> controller  word-aligned address
//   cache_ctrl_data_o        unit -> controller  lane-aligned write data
//   cache_ctrl_byte_enable_o unit -> controller  byte lanes to write
//   cache_ctrl_cachable_o    unit -> controller  address lies in a cachable region
`timescale 1ns/1ps

package store_unit_pkg;

  typedef enum logic [1:0] {
    STU_SB   = 2'd0,
    STU_SH   = 2'd1,
    STU_SW   = 2'd2,
    STU_RSVD = 2'd3
  } stu_operation_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd_tag;
    logic [5:0]  rob_id;
  } instr_packet_t;

  // core memory map, inclusive bounds
  localparam logic [31:0] INT_TABLE_LO = 32'h0000_0000;
  localparam logic [31:0] INT_TABLE_HI = 32'h0000_03FF;
  localparam logic [31:0] CODE_LO      = 32'h0000_0400;
  localparam logic [31:0] CODE_HI      = 32'h0000_FFFF;
  localparam logic [31:0] INT_NVM_LO   = 32'h0001_0000;
  localparam logic [31:0] INT_NVM_HI   = 32'h0003_FFFF;
  localparam logic [31:0] EXT_NVM_LO   = 32'h1000_0000;
  localparam logic [31:0] EXT_NVM_HI   = 32'h1FFF_FFFF;

endpackage

interface store_unit_if #(parameter int XLEN = 32);
  logic            cache_ctrl_idle_i;
  logic            cache_ctrl_write_done_i;
  logic            cache_ctrl_write_o;
  logic [XLEN-1:0] cache_ctrl_address_o;
  logic [XLEN-1:0] cache_ctrl_data_o;
  logic [3:0]      cache_ctrl_byte_enable_o;
  logic            cache_ctrl_cachable_o;

  modport master (
    input  cache_ctrl_idle_i, cache_ctrl_write_done_i,
    output cache_ctrl_write_o, cache_ctrl_address_o, cache_ctrl_data_o,
           cache_ctrl_byte_enable_o, cache_ctrl_cachable_o
  );

  modport slave (
    output cache_ctrl_idle_i, cache_ctrl_write_done_i,
    input  cache_ctrl_write_o, cache_ctrl_address_o, cache_ctrl_data_o,
           cache_ctrl_byte_enable_o, cache_ctrl_cachable_o
  );
endinterface

// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32 store execution unit (SB/SH/SW) issuing writes to the data cache controller
//
// Ports:
//   clk_i, rst_n_i       clock, asynchronous active-low reset
//   valid_operation_i    store request, sampled only in IDLE
//   store_address_i      byte address
//   store_data_i         rs2 value
//   operation_i          SB / SH / SW / reserved
//   instr_packet_i/_o    instruction metadata in, registered copy out (valid with done_o)
//   idle_o               unit can accept a request
//   done_o               one-cycle pulse: store retired or faulted
//   misaligned_o         qualifies done_o: store faulted, no write performed
//   ctrl                 cache controller write bus (store_unit_if.master)
`timescale 1ns/1ps

module store_unit
  import store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            valid_operation_i,
  input  logic [XLEN-1:0] store_address_i,
  input  logic [XLEN-1:0] store_data_i,
  input  stu_operation_t  operation_i,
  input  instr_packet_t   instr_packet_i,
  output instr_packet_t   instr_packet_o,
  output logic            idle_o,
  output logic            done_o,
  output logic            misaligned_o,
  store_unit_if.master    ctrl
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CTRL,
    S_WRITE,
    S_DONE,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic          write_q, write_d;
  logic          done_q, done_d;
  logic          mis_q, mis_d;
  logic [3:0]    be_q;
  logic [31:0]   addr_q, data_q;
  instr_packet_t pkt_q;

  logic          accept;
  logic          fault_in;
  logic [3:0]    be_in;
  logic [31:0]   data_in;

  assign accept = (state_q == S_IDLE) && valid_operation_i;

  // lane alignment, byte enables and fault detection from the incoming request
  always_comb begin
    be_in    = 4'b0000;
    data_in  = store_data_i;
    fault_in = 1'b0;
    case (operation_i)
      STU_SB: begin
        be_in   = 4'b0001 << store_address_i[1:0];
        data_in = {4{store_data_i[7:0]}};
      end
      STU_SH: begin
        be_in    = store_address_i[1] ? 4'b1100 : 4'b0011;
        data_in  = {2{store_data_i[15:0]}};
        fault_in = store_address_i[0];
      end
      STU_SW: begin
        be_in    = 4'b1111;
        fault_in = |store_address_i[1:0];
      end
      default: fault_in = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_operation_i) begin
          if (fault_in) begin
            state_d = S_FAULT;
          end else if (ctrl.cache_ctrl_idle_i) begin
            state_d = S_WRITE;
            write_d = 1'b1;
          end else begin
            state_d = S_WAIT_CTRL;
          end
        end
      end
      S_WAIT_CTRL: begin
        if (ctrl.cache_ctrl_idle_i) begin
          state_d = S_WRITE;
          write_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (ctrl.cache_ctrl_write_done_i) begin
          state_d = S_DONE;
          write_d = 1'b0;
        end
      end
      // done/misaligned are registered, so the pulse appears on the edge leaving these states
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_FAULT: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        mis_d   = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      be_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      // a faulting store leaves the previous enables in place; they are never presented
      if (accept && !fault_in) begin
        be_q <= be_in;
      end
    end
  end

  // payload registers need no reset: they are only observed after an accept
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q <= store_address_i;
      data_q <= data_in;
      pkt_q  <= instr_packet_i;
    end
  end

  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  assign ctrl.cache_ctrl_write_o       = write_q;
  assign ctrl.cache_ctrl_address_o     = {addr_q[31:2], 2'b00};
  assign ctrl.cache_ctrl_data_o        = data_q;
  assign ctrl.cache_ctrl_byte_enable_o = be_q;
  assign ctrl.cache_ctrl_cachable_o    = in_range(addr_q, INT_TABLE_LO, INT_TABLE_HI)
                                       | in_range(addr_q, EXT_NVM_LO, EXT_NVM_HI)
                                       | in_range(addr_q, INT_NVM_LO, INT_NVM_HI)
                                       | in_range(addr_q, CODE_LO, CODE_HI);

  assign instr_packet_o = pkt_q;
  assign idle_o         = (state_q == S_IDLE);
  assign done_o         = done_q;
  assign misaligned_o   = mis_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - self-checking bench for store_unit with a behavioural store model
`timescale 1ns/1ps

module tb_store_unit;
  import store_unit_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid = 1'b0;
  logic [31:0]    addr = '0;
  logic [31:0]    data = '0;
  stu_operation_t op = STU_SB;
  instr_packet_t  pkt_in = '0;
  instr_packet_t  pkt_out;
  logic           idle, done, mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_unit_if bus ();

  store_unit dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .valid_operation_i (valid),
    .store_address_i   (addr),
    .store_data_i      (data),
    .operation_i       (op),
    .instr_packet_i    (pkt_in),
    .instr_packet_o    (pkt_out),
    .idle_o            (idle),
    .done_o            (done),
    .misaligned_o      (mis),
    .ctrl              (bus.master)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // reference model: store rules in plain arithmetic
  function automatic bit m_fault(input int o, input logic [31:0] a);
    if (o == 3) return 1'b1;
    if (o == 1) return (a % 2) != 0;
    if (o == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input int o, input logic [31:0] a);
    if (o == 0) return 4'(1 << (a % 4));
    if (o == 1) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] m_data(input int o, input logic [31:0] d);
    if (o == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (o == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic m_cach(input logic [31:0] a);
    return (a >= INT_TABLE_LO && a <= INT_TABLE_HI) || (a >= CODE_LO && a <= CODE_HI) ||
           (a >= INT_NVM_LO && a <= INT_NVM_HI) || (a >= EXT_NVM_LO && a <= EXT_NVM_HI);
  endfunction

  function automatic instr_packet_t rand_pkt();
    instr_packet_t p;
    p.pc     = $urandom;
    p.rd_tag = 5'($urandom);
    p.rob_id = 6'($urandom);
    return p;
  endfunction

  task automatic check_bus(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                           input logic [3:0] eb, input logic ec);
    check_eq({tag, "_write"}, bus.cache_ctrl_write_o, 1'b1);
    check_eq({tag, "_addr"}, bus.cache_ctrl_address_o, ea);
    check_eq({tag, "_data"}, bus.cache_ctrl_data_o, ed);
    check_eq({tag, "_be"}, bus.cache_ctrl_byte_enable_o, eb);
    check_eq({tag, "_cach"}, bus.cache_ctrl_cachable_o, ec);
  endtask

  // one complete store; idle_dly = cycles the controller stays busy after accept,
  // done_dly = WRITE cycles before write_done; poke injects a request during the wait
  task automatic run_store(input int o, input logic [31:0] a, input logic [31:0] d,
                           input int idle_dly, input int done_dly, input bit poke);
    instr_packet_t p;
    logic [31:0]   ea, ed;
    logic [3:0]    eb;
    logic          ec;
    int            n;
    p  = rand_pkt();
    ea = a - (a % 4);
    ed = m_data(o, d);
    eb = m_be(o, a);
    ec = m_cach(a);
    check_eq("idle_before", idle, 1'b1);
    valid  = 1'b1;
    addr   = a;
    data   = d;
    op     = stu_operation_t'(o[1:0]);
    pkt_in = p;
    bus.cache_ctrl_idle_i = (idle_dly == 0);
    step();
    n      = 0;
    valid  = 1'b0;
    addr   = $urandom;
    data   = $urandom;
    pkt_in = rand_pkt();
    if (m_fault(o, a)) begin
      check_eq("fault_no_write", bus.cache_ctrl_write_o, 1'b0);
      check_eq("fault_early_done", done, 1'b0);
      step();
      check_eq("fault_done", done, 1'b1);
      check_eq("fault_mis", mis, 1'b1);
      check_eq("fault_no_write2", bus.cache_ctrl_write_o, 1'b0);
      check_eq("fault_pkt", pkt_out, p);
      step();
      check_eq("fault_done_pulse", done, 1'b0);
    end else begin
      for (int i = 1; i < idle_dly; i++) begin
        check_eq("wait_write", bus.cache_ctrl_write_o, 1'b0);
        check_eq("wait_idle", idle, 1'b0);
        if (poke && i == 1) begin
          valid = 1'b1;
          op    = stu_operation_t'(2'($urandom));
        end
        step();
        n++;
        valid = 1'b0;
      end
      if (idle_dly > 0) begin
        check_eq("wait_write_last", bus.cache_ctrl_write_o, 1'b0);
        bus.cache_ctrl_idle_i = 1'b1;
        step();
        n++;
      end
      check_bus("issue", ea, ed, eb, ec);
      for (int i = 0; i < done_dly; i++) begin
        bus.cache_ctrl_idle_i = 1'($urandom);
        step();
        n++;
        check_bus("hold", ea, ed, eb, ec);
        check_eq("hold_nodone", done, 1'b0);
      end
      bus.cache_ctrl_write_done_i = 1'b1;
      step();
      n++;
      bus.cache_ctrl_write_done_i = 1'b0;
      check_eq("done_state_write", bus.cache_ctrl_write_o, 1'b0);
      check_eq("done_state_nodone", done, 1'b0);
      step();
      n++;
      check_eq("done", done, 1'b1);
      check_eq("done_mis", mis, 1'b0);
      check_eq("done_pkt", pkt_out, p);
      check_eq("done_latency", n, idle_dly + done_dly + 2);
      step();
      check_eq("done_pulse", done, 1'b0);
    end
    bus.cache_ctrl_idle_i = 1'b1;
  endtask

  task automatic idle_done_pulse();
    bus.cache_ctrl_write_done_i = 1'b1;
    step();
    bus.cache_ctrl_write_done_i = 1'b0;
    check_eq("idle_wd_idle", idle, 1'b1);
    check_eq("idle_wd_write", bus.cache_ctrl_write_o, 1'b0);
    check_eq("idle_wd_done", done, 1'b0);
    step();
    check_eq("idle_wd_done2", done, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0:       a = $urandom_range(0, 32'h3FF);
      1:       a = $urandom_range(32'h400, 32'hFFFF);
      2:       a = $urandom_range(32'h1_0000, 32'h3_FFFF);
      3:       a = 32'h1000_0000 + ($urandom & 32'h0FFF_FFFF);
      default: a = 32'h2000_0000 + $urandom_range(0, 32'h0FFF_FFFF);
    endcase
    return a;
  endfunction

  initial begin
    bus.cache_ctrl_idle_i       = 1'b1;
    bus.cache_ctrl_write_done_i = 1'b0;
    step();
    step();
    check_eq("rst_idle", idle, 1'b1);
    check_eq("rst_write", bus.cache_ctrl_write_o, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_mis", mis, 1'b0);
    check_eq("rst_be", bus.cache_ctrl_byte_enable_o, 4'b0000);
    rst_n = 1'b1;
    step();

    run_store(2, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_store(0, 32'h0000_2003, 32'h1234_56AB, 0, 0, 1'b0);
    run_store(1, 32'h0000_2002, 32'h0000_CAFE, 0, 0, 1'b0);
    run_store(1, 32'h0000_2001, 32'h1111_2222, 0, 0, 1'b0);
    run_store(2, 32'h0000_2002, 32'h3333_4444, 0, 0, 1'b0);
    run_store(3, 32'h0000_2000, 32'h5555_6666, 0, 0, 1'b0);
    run_store(2, 32'h0000_3000, 32'hA5A5_5A5A, 5, 0, 1'b1);
    run_store(2, 32'h0001_0004, 32'h0F0F_F0F0, 0, 10, 1'b0);
    idle_done_pulse();
    run_store(2, 32'h0003_FFFC, 32'h0000_0001, 0, 1, 1'b0);
    run_store(2, 32'h0004_0000, 32'h0000_0002, 0, 1, 1'b0);
    run_store(0, 32'h0FFF_FFFF, 32'h0000_0003, 1, 0, 1'b0);
    run_store(0, 32'h2000_0000, 32'h0000_0004, 0, 0, 1'b0);

    // reset in the middle of WRITE
    valid = 1'b1;
    addr  = 32'h0000_4000;
    data  = 32'h7777_8888;
    op    = STU_SW;
    step();
    valid = 1'b0;
    check_eq("rst_mid_issue", bus.cache_ctrl_write_o, 1'b1);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_write", bus.cache_ctrl_write_o, 1'b0);
    check_eq("rst_mid_idle", idle, 1'b1);
    check_eq("rst_mid_done", done, 1'b0);
    bus.cache_ctrl_write_done_i = 1'b1;
    step();
    bus.cache_ctrl_write_done_i = 1'b0;
    check_eq("rst_hold_done", done, 1'b0);
    rst_n = 1'b1;
    step();
    check_eq("rst_after_done", done, 1'b0);
    run_store(2, 32'h0000_4000, 32'h7777_8888, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] ra;
      int          ro;
      ro = $urandom_range(0, 3);
      ra = rand_addr();
      // bias towards legal alignment so most iterations reach the write path
      if ($urandom_range(0, 3) != 0) begin
        if (ro == 1) ra = ra & ~32'h1;
        if (ro == 2) ra = ra & ~32'h3;
      end
      run_store(ro, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 4),
                1'($urandom));
      if ($urandom_range(0, 7) == 0) idle_done_pulse();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
